// File: rtl/number_value_bank.sv
// number_value_bank: LFSR-driven digit bank for the 12-slot number display.
// Values are drawn into a shadow copy and committed to the display outputs
// only on startOfFrame so a digit never changes mid-frame.

// One display slot: shadow value being drawn, committed value and shown flag.
module number_value_bank_slot #(
  parameter int VALUE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [VALUE_W-1:0] wr_val,
  input  logic               commit,
  input  logic               clr,
  output logic [VALUE_W-1:0] value,
  output logic               valid
);
  logic [VALUE_W-1:0] shadow;

  // Shadow takes new draws; the committed value follows it only on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      value  <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr)     shadow <= wr_val;
      if (commit) value  <= shadow;
      if (commit)   valid <= 1'b1;
      else if (clr) valid <= 1'b0;
    end
  end
endmodule

module number_value_bank #(
  parameter int          NUM_SLOTS = 12,
  parameter int          VALUE_W   = 4,
  parameter int          MAX_VALUE = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              startOfFrame,
  input  logic                              hitValid,
  input  logic [3:0]                        hitIdx,
  input  logic                              refillAll,
  output logic [NUM_SLOTS-1:0][VALUE_W-1:0] values,
  output logic [NUM_SLOTS-1:0]              slotValid,
  output logic                              busy,
  output logic                              hitDropped
);
  typedef enum logic [1:0] {IDLE, FILL, REFILL_ONE, COMMIT_WAIT} state_t;

  state_t             state, state_d;
  logic [15:0]        lfsr;
  logic [3:0]         slot_ptr, slot_ptr_d;
  logic [3:0]         target, target_d;
  logic [VALUE_W-1:0] cand;
  logic               accepted, hit_ok;
  logic               wr_en, commit, clr_en, drop_d;
  logic [3:0]         wr_idx;

  // Candidate is taken from the LFSR before this cycle's shift.
  assign cand     = lfsr[VALUE_W-1:0];
  assign accepted = (cand <= VALUE_W'(MAX_VALUE));
  assign hit_ok   = hitValid && ({1'b0, hitIdx} < 5'(NUM_SLOTS));
  assign busy     = (state != IDLE);

  // Free-running Fibonacci LFSR (taps 16,14,13,11), never paused by state.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Control registers: state, fill pointer, refill target, drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      slot_ptr   <= '0;
      target     <= '0;
      hitDropped <= 1'b0;
    end else begin
      state      <= state_d;
      slot_ptr   <= slot_ptr_d;
      target     <= target_d;
      hitDropped <= drop_d;
    end
  end

  // Next-state and slot write/commit strobes.
  always_comb begin
    state_d    = state;
    slot_ptr_d = slot_ptr;
    target_d   = target;
    wr_en      = 1'b0;
    wr_idx     = slot_ptr;
    commit     = 1'b0;
    clr_en     = 1'b0;
    // Any legal hit outside IDLE is reported and otherwise ignored.
    drop_d     = hit_ok && (state != IDLE);
    case (state)
      FILL: begin
        if (accepted) begin
          wr_en = 1'b1;
          if (slot_ptr == 4'(NUM_SLOTS-1)) begin
            slot_ptr_d = '0;
            state_d    = COMMIT_WAIT;
          end else begin
            slot_ptr_d = slot_ptr + 4'd1;
          end
        end
      end
      IDLE: begin
        // refillAll wins over a simultaneous hit, which is simply discarded.
        if (refillAll) begin
          slot_ptr_d = '0;
          state_d    = FILL;
        end else if (hit_ok) begin
          clr_en   = 1'b1;
          target_d = hitIdx;
          state_d  = REFILL_ONE;
        end
      end
      REFILL_ONE: begin
        // Redraw must differ from the digit just hit.
        wr_idx = target;
        if (accepted && (cand != values[target])) begin
          wr_en   = 1'b1;
          state_d = COMMIT_WAIT;
        end
      end
      COMMIT_WAIT: begin
        if (startOfFrame) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    number_value_bank_slot #(.VALUE_W(VALUE_W)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr_en && (wr_idx == 4'(i))),
      .wr_val (cand),
      .commit (commit),
      .clr    (clr_en && (hitIdx == 4'(i))),
      .value  (values[i]),
      .valid  (slotValid[i])
    );
  end
endmodule

// File: tb/tb_number_value_bank.sv
// Bench for number_value_bank: directed scenarios plus a random run, all
// checked against a queue-based model of draws and frame-aligned commits.
module tb_number_value_bank;
  localparam int N = 12, W = 4, MAXV = 9;

  logic clk = 0, reset = 1, startOfFrame = 0, hitValid = 0, refillAll = 0;
  logic [3:0] hitIdx = 0;
  logic [N-1:0][W-1:0] values;
  logic [N-1:0] slotValid;
  logic busy, hitDropped;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  number_value_bank dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hitValid(hitValid),
    .hitIdx(hitIdx), .refillAll(refillAll), .values(values),
    .slotValid(slotValid), .busy(busy), .hitDropped(hitDropped)
  );

  // Model: a random sequence, a list of slots still needing a draw, and a
  // pending-commit flag.
  logic [15:0] m_lfsr;
  int m_sh[N];
  int m_val[N];
  logic [N-1:0] m_valid;
  int m_todo[$];
  bit m_one, m_wait;
  logic m_drop;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic bit m_busy();
    return (m_todo.size() != 0) || m_wait;
  endfunction

  function automatic logic [N*W-1:0] m_vals();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m_val[i][W-1:0];
    return r;
  endfunction

  task automatic model_step();
    int c;
    bit acc, hit;
    c = int'(m_lfsr[3:0]);
    acc = (c <= MAXV);
    hit = hitValid && (hitIdx < N);
    if (reset) begin
      m_lfsr = 16'hACE1;
      m_todo.delete();
      for (int i = 0; i < N; i++) begin m_todo.push_back(i); m_sh[i] = 0; m_val[i] = 0; end
      m_one = 0; m_wait = 0; m_drop = 0; m_valid = '0;
    end else begin
      m_drop = hit && m_busy();
      if (m_todo.size() != 0) begin
        if (m_one) begin
          if (acc && c != m_val[m_todo[0]]) begin
            m_sh[m_todo[0]] = c;
            void'(m_todo.pop_front());
            m_wait = 1;
          end
        end else if (acc) begin
          m_sh[m_todo.pop_front()] = c;
          if (m_todo.size() == 0) m_wait = 1;
        end
      end else if (m_wait) begin
        if (startOfFrame) begin
          for (int i = 0; i < N; i++) m_val[i] = m_sh[i];
          m_valid = '1;
          m_wait = 0;
        end
      end else if (refillAll) begin
        for (int i = 0; i < N; i++) m_todo.push_back(i);
        m_one = 0;
      end else if (hit) begin
        m_valid[hitIdx] = 1'b0;
        m_todo.push_back(int'(hitIdx));
        m_one = 1;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1ns later,
  // pulse inputs drop after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    startOfFrame = 0; hitValid = 0; refillAll = 0;
  endtask

  // Run until the pending commit is armed, then give one frame pulse.
  task automatic run_to_commit();
    for (int k = 0; k < 300 && !m_wait; k++) tick();
    checks++;
    if (!m_wait || busy !== 1'b1) begin
      errors++;
      $display("FAIL commit_wait_reach: busy=%0b model_wait=%0b required busy=1 wait=1", busy, m_wait);
    end
    startOfFrame = 1;
    tick();
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b want 1", busy); end
    checks++; if (values !== '0) begin errors++; $display("FAIL reset_values: got %h want 0", values); end
    checks++; if (slotValid !== '0) begin errors++; $display("FAIL reset_valid: got %h want 0", slotValid); end
    reset = 0;
    bad = 0;
    for (int k = 0; k < 300 && !m_wait; k++) begin
      tick();
      if (slotValid !== '0 || values !== '0 || busy !== 1'b1) bad = 1;
    end
    checks++; if (bad || !m_wait) begin errors++; $display("FAIL fill_hidden: outputs changed before commit or fill stalled, valid=%h", slotValid); end
    startOfFrame = 1;
    tick();
    checks++; if (slotValid !== 12'hFFF) begin errors++; $display("FAIL first_commit_valid: got %h want fff", slotValid); end
    checks++; if (values[0] !== 4'd1) begin errors++; $display("FAIL first_value0: got %0d want 1", values[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_commit_busy: got %0b want 0", busy); end
    bad = 0;
    for (int i = 0; i < N; i++) if (values[i] > MAXV) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL value_range: values=%h some exceed 9", values); end
    checks++; if (values !== m_vals()) begin errors++; $display("FAIL first_values: got %h want %h", values, m_vals()); end
  endtask

  task automatic test_hit();
    logic [N-1:0][W-1:0] old;
    bit bad;
    old = values;
    hitValid = 1; hitIdx = 5;
    tick();
    checks++; if (slotValid !== 12'hFDF) begin errors++; $display("FAIL hit5_valid: got %h want fdf", slotValid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hit5_busy: got %0b want 1", busy); end
    run_to_commit();
    checks++; if (slotValid !== 12'hFFF) begin errors++; $display("FAIL hit5_recommit: got %h want fff", slotValid); end
    checks++; if (values[5] === old[5] || values[5] > MAXV) begin errors++; $display("FAIL hit5_redraw: got %0d old %0d want different and <=9", values[5], old[5]); end
    bad = 0;
    for (int i = 0; i < N; i++) if (i != 5 && values[i] !== old[i]) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL hit5_others: got %h old %h", values, old); end
    checks++; if (values !== m_vals()) begin errors++; $display("FAIL hit5_model: got %h want %h", values, m_vals()); end
  endtask

  task automatic test_bad_idx();
    logic [N-1:0][W-1:0] old;
    old = values;
    foreach (old[j]) begin end
    for (int t = 12; t < 16; t += 3) begin
      hitValid = 1; hitIdx = 4'(t);
      tick();
      checks++;
      if (slotValid !== 12'hFFF || values !== old || busy !== 1'b0 || hitDropped !== 1'b0) begin
        errors++;
        $display("FAIL bad_idx_%0d: valid=%h busy=%0b drop=%0b values=%h want fff/0/0/%h", t, slotValid, busy, hitDropped, values, old);
      end
    end
  endtask

  task automatic test_drop();
    hitValid = 1; hitIdx = 0;
    tick();
    hitValid = 1; hitIdx = 2;
    tick();
    checks++; if (hitDropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b want 1", hitDropped); end
    checks++; if (slotValid[2] !== 1'b1) begin errors++; $display("FAIL drop_valid2: got %0b want 1", slotValid[2]); end
    tick();
    checks++; if (hitDropped !== 1'b0) begin errors++; $display("FAIL drop_width: got %0b want 0", hitDropped); end
    run_to_commit();
    checks++; if (values !== m_vals() || slotValid !== 12'hFFF) begin errors++; $display("FAIL drop_commit: got %h/%h want %h/fff", values, slotValid, m_vals()); end
  endtask

  task automatic test_refill_hit();
    logic [N-1:0][W-1:0] old;
    old = values;
    refillAll = 1; hitValid = 1; hitIdx = 3;
    tick();
    checks++; if (slotValid !== 12'hFFF || busy !== 1'b1) begin errors++; $display("FAIL refill_hit: valid=%h busy=%0b want fff/1", slotValid, busy); end
    tick(); tick();
    checks++; if (values !== old) begin errors++; $display("FAIL refill_hold: got %h want %h", values, old); end
    run_to_commit();
    checks++; if (values !== m_vals() || slotValid !== 12'hFFF) begin errors++; $display("FAIL refill_commit: got %h/%h want %h/fff", values, slotValid, m_vals()); end
  endtask

  task automatic test_reset_in_commit_wait();
    refillAll = 1;
    tick();
    for (int k = 0; k < 300 && !m_wait; k++) tick();
    reset = 1;
    tick();
    reset = 0;
    checks++; if (values !== '0 || slotValid !== '0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset: values=%h valid=%h busy=%0b want 0/0/1", values, slotValid, busy); end
    run_to_commit();
    checks++; if (values[0] !== 4'd1 || slotValid !== 12'hFFF) begin errors++; $display("FAIL mid_reset_slot0: got %0d/%h want 1/fff", values[0], slotValid); end
    checks++; if (values !== m_vals()) begin errors++; $display("FAIL mid_reset_model: got %h want %h", values, m_vals()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      startOfFrame = ($urandom_range(0, 7) == 0);
      hitValid     = ($urandom_range(0, 9) == 0);
      hitIdx       = 4'($urandom_range(0, 15));
      refillAll    = ($urandom_range(0, 149) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
      reset = 0;
      checks++;
      if (busy !== m_busy() || values !== m_vals() || slotValid !== m_valid || hitDropped !== m_drop) begin
        errors++;
        $display("FAIL random_c%0d: busy=%0b drop=%0b valid=%h values=%h want %0b/%0b/%h/%h",
                 k, busy, hitDropped, slotValid, values, m_busy(), m_drop, m_valid, m_vals());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_bad_idx();
    test_drop();
    test_refill_hit();
    test_reset_in_commit_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
